// File: rtl/load_queue_pkg.sv
// Shared types for the load queue.
//   lq_state_e  - life cycle of one queue entry
//   lq_entry_t  - one entry record (state, ROB index, address) at the
//                 default core widths
//   LQ_ROB_DEPTH / LQ_DATA_W / LQ_ADDR_W - core-wide defaults shared with
//                 the reorder buffer
package load_queue_pkg;

  localparam int LQ_ROB_DEPTH = 8;
  localparam int LQ_DATA_W    = 32;
  localparam int LQ_ADDR_W    = 32;
  localparam int LQ_ROB_IX_W  = $clog2(LQ_ROB_DEPTH);

  typedef enum logic [2:0] {
    LQ_FREE      = 3'd0,
    LQ_WAIT_ADDR = 3'd1,
    LQ_READY     = 3'd2,
    LQ_ISSUED    = 3'd3,
    LQ_DONE      = 3'd4,
    LQ_ZOMBIE    = 3'd5
  } lq_state_e;

  typedef struct packed {
    lq_state_e                state;
    logic [LQ_ROB_IX_W-1:0]   rob_ix;
    logic [LQ_ADDR_W-1:0]     addr;
  } lq_entry_t;

endpackage

// File: rtl/lq_age_select.sv
// Oldest-first selector: rotates the request vector so that 'head' is
// position 0, then priority-encodes the lowest set position.
// Ports:
//   req   - one bit per entry, set when the entry is a candidate
//   head  - index of the oldest entry
//   idx   - index of the oldest candidate (0 when none)
//   found - at least one candidate exists
// N must be a power of two so the index addition wraps naturally.
module lq_age_select #(
  parameter int N    = 8,
  parameter int IX_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IX_W-1:0] head,
  output logic [IX_W-1:0] idx,
  output logic            found
);

  logic [IX_W-1:0] pos;

  // Walk from youngest to oldest so the oldest hit is the last write.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = head + IX_W'(k);
      if (req[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/load_queue.sv
// Load queue: holds in-flight loads between dispatch and the memory unit.
// Entries are allocated and retired in order (circular head/tail with a
// wrap bit), capture their address from the AGU broadcast, issue to memory
// once the ROB allows it, and return data on the CDB. A flush squashes all
// entries; loads already at memory become zombies and must drain before
// the queue accepts new work.
//
// Configuration macro: LOAD_QUEUE_IN_ORDER_EN
//   defined   - only the oldest non-issued entry may issue (in-order issue)
//   undefined - oldest eligible entry issues (out-of-order issue)
//
// Ports:
//   clk_in, rst_in (async, active-low)
//   alloc_*      dispatch interface (valid / rob index / ready)
//   addr_*       AGU address broadcast
//   can_load_in  per-ROB-entry permission to access memory
//   flush_in     squash all queued loads
//   mem_req_*    request to memory (valid / ready / addr / tag)
//   mem_resp_*   response from memory (valid / tag / data)
//   cdb_*        result broadcast (valid / rob index / data)
//   count_out    number of occupied entries
module load_queue
  import load_queue_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int ROB_DEPTH = LQ_ROB_DEPTH,
  parameter int ROB_IX_W  = $clog2(ROB_DEPTH),
  parameter int ADDR_W    = LQ_ADDR_W,
  parameter int DATA_W    = LQ_DATA_W
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     alloc_valid_in,
  input  logic [ROB_IX_W-1:0]      alloc_rob_ix_in,
  output logic                     alloc_ready_out,
  input  logic                     addr_valid_in,
  input  logic [ROB_IX_W-1:0]      addr_rob_ix_in,
  input  logic [ADDR_W-1:0]        addr_in,
  input  logic [ROB_DEPTH-1:0]     can_load_in,
  input  logic                     flush_in,
  output logic                     mem_req_valid_out,
  input  logic                     mem_req_ready_in,
  output logic [ADDR_W-1:0]        mem_req_addr_out,
  output logic [$clog2(DEPTH)-1:0] mem_req_tag_out,
  input  logic                     mem_resp_valid_in,
  input  logic [$clog2(DEPTH)-1:0] mem_resp_tag_in,
  input  logic [DATA_W-1:0]        mem_resp_data_in,
  output logic                     cdb_valid_out,
  output logic [ROB_IX_W-1:0]      cdb_rob_ix_out,
  output logic [DATA_W-1:0]        cdb_data_out,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int IX_W  = $clog2(DEPTH);
  localparam int PTR_W = IX_W + 1;

  lq_state_e             st_q   [DEPTH];
  lq_state_e             st_nxt [DEPTH];
  logic [ROB_IX_W-1:0]   rob_q  [DEPTH];
  logic [ADDR_W-1:0]     addr_q [DEPTH];

  logic [PTR_W-1:0]      head_q, tail_q, head_nxt, tail_nxt;
  logic [IX_W-1:0]       head_ix, tail_ix;
  logic                  draining_q, draining_nxt;
  logic                  full;
  logic                  zombie_left;

  logic                  alloc_fire;
  logic                  retire;
  logic [DEPTH-1:0]      cap_vec;
  logic                  resp_issued, resp_zombie;

  logic [DEPTH-1:0]      cand;
  logic [IX_W-1:0]       cand_idx;
  logic                  cand_found;
  logic                  pick_found;
  logic                  lock_q;
  logic [IX_W-1:0]       lock_tag_q;
  logic [IX_W-1:0]       sel_idx;
  logic                  req_valid;
  logic                  issue_fire;

  logic                  cdb_vld_q;
  logic [ROB_IX_W-1:0]   cdb_rob_q;
  logic [DATA_W-1:0]     cdb_data_q;

  assign head_ix   = head_q[IX_W-1:0];
  assign tail_ix   = tail_q[IX_W-1:0];
  assign count_out = tail_q - head_q;
  assign full      = (count_out == PTR_W'(DEPTH));

  assign alloc_ready_out = !full && !draining_q;
  assign alloc_fire      = alloc_valid_in && alloc_ready_out && !flush_in;

  // Capture looks at the current state only, so an entry allocated this
  // cycle (still FREE) cannot pick up a same-cycle broadcast.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cap_vec[i] = !flush_in && addr_valid_in &&
                   (st_q[i] == LQ_WAIT_ADDR) && (rob_q[i] == addr_rob_ix_in);
    end
  end

  assign resp_issued = mem_resp_valid_in && (st_q[mem_resp_tag_in] == LQ_ISSUED);
  assign resp_zombie = mem_resp_valid_in && (st_q[mem_resp_tag_in] == LQ_ZOMBIE);

  // Issue candidate selection
`ifdef LOAD_QUEUE_IN_ORDER_EN
  // Oldest entry that has not yet gone to memory; it issues only when it
  // is itself ready and permitted, which keeps issue in allocation order.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cand[i] = (st_q[i] == LQ_WAIT_ADDR) || (st_q[i] == LQ_READY);
    end
  end
  assign pick_found = cand_found && (st_q[cand_idx] == LQ_READY) &&
                      can_load_in[rob_q[cand_idx]];
`else
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cand[i] = (st_q[i] == LQ_READY) && can_load_in[rob_q[i]];
    end
  end
  assign pick_found = cand_found;
`endif

  lq_age_select #(
    .N    (DEPTH),
    .IX_W (IX_W)
  ) u_age_select (
    .req   (cand),
    .head  (head_ix),
    .idx   (cand_idx),
    .found (cand_found)
  );

  // A stalled request is pinned to its entry so address/tag cannot move
  // under the memory unit even if an older entry becomes eligible.
  assign sel_idx    = lock_q ? lock_tag_q : cand_idx;
  assign req_valid  = !flush_in && (lock_q || pick_found);
  assign issue_fire = req_valid && mem_req_ready_in;

  assign mem_req_valid_out = req_valid;
  assign mem_req_addr_out  = req_valid ? addr_q[sel_idx] : '0;
  assign mem_req_tag_out   = req_valid ? sel_idx : '0;

  assign retire = !draining_q && (st_q[head_ix] == LQ_DONE);

  always_comb begin
    st_nxt       = st_q;
    head_nxt     = head_q;
    tail_nxt     = tail_q;
    draining_nxt = draining_q;
    zombie_left  = 1'b0;

    if (flush_in) begin
      // A load answered in the flush cycle is simply dropped.
      for (int i = 0; i < DEPTH; i++) begin
        if (st_q[i] == LQ_ISSUED || st_q[i] == LQ_ZOMBIE) begin
          if (mem_resp_valid_in && mem_resp_tag_in == IX_W'(i))
            st_nxt[i] = LQ_FREE;
          else
            st_nxt[i] = LQ_ZOMBIE;
        end else begin
          st_nxt[i] = LQ_FREE;
        end
      end
    end else begin
      if (resp_issued) st_nxt[mem_resp_tag_in] = LQ_DONE;
      if (resp_zombie) st_nxt[mem_resp_tag_in] = LQ_FREE;
      for (int i = 0; i < DEPTH; i++) begin
        if (cap_vec[i]) st_nxt[i] = LQ_READY;
      end
      if (issue_fire) st_nxt[sel_idx] = LQ_ISSUED;
      if (alloc_fire) begin
        st_nxt[tail_ix] = LQ_WAIT_ADDR;
        tail_nxt        = tail_q + 1'b1;
      end
      if (retire) begin
        st_nxt[head_ix] = LQ_FREE;
        head_nxt        = head_q + 1'b1;
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (st_nxt[i] == LQ_ZOMBIE) zombie_left = 1'b1;
    end

    // Pointers restart at zero once nothing is left in memory from before
    // the flush; until then the queue refuses new loads.
    if ((flush_in || draining_q) && !zombie_left) begin
      head_nxt     = '0;
      tail_nxt     = '0;
      draining_nxt = 1'b0;
    end else if (flush_in) begin
      draining_nxt = 1'b1;
    end
  end

  // Control state
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) st_q[i] <= LQ_FREE;
      head_q     <= '0;
      tail_q     <= '0;
      draining_q <= 1'b0;
      lock_q     <= 1'b0;
      lock_tag_q <= '0;
      cdb_vld_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) st_q[i] <= st_nxt[i];
      head_q     <= head_nxt;
      tail_q     <= tail_nxt;
      draining_q <= draining_nxt;
      if (flush_in || mem_req_ready_in) begin
        lock_q <= 1'b0;
      end else if (req_valid) begin
        lock_q     <= 1'b1;
        lock_tag_q <= sel_idx;
      end
      cdb_vld_q <= resp_issued && !flush_in;
    end
  end

  // Payload registers (validity is tracked by the control state above)
  always_ff @(posedge clk_in) begin
    if (alloc_fire) rob_q[tail_ix] <= alloc_rob_ix_in;
    for (int i = 0; i < DEPTH; i++) begin
      if (cap_vec[i]) addr_q[i] <= addr_in;
    end
    if (resp_issued) begin
      cdb_rob_q  <= rob_q[mem_resp_tag_in];
      cdb_data_q <= mem_resp_data_in;
    end
  end

  // A flush in the broadcast cycle kills the pending result.
  assign cdb_valid_out  = cdb_vld_q && !flush_in;
  assign cdb_rob_ix_out = cdb_valid_out ? cdb_rob_q : '0;
  assign cdb_data_out   = cdb_valid_out ? cdb_data_q : '0;

`ifndef SYNTHESIS
  // FREE is tolerated: responses to loads squashed by reset land there.
  always_ff @(posedge clk_in) begin
    if (rst_in && mem_resp_valid_in) begin
      assert (st_q[mem_resp_tag_in] == LQ_FREE ||
              st_q[mem_resp_tag_in] == LQ_ISSUED ||
              st_q[mem_resp_tag_in] == LQ_ZOMBIE)
        else $error("load_queue: response for tag %0d in state %0d",
                    mem_resp_tag_in, st_q[mem_resp_tag_in]);
    end
  end
`endif

endmodule

// File: tb/tb_load_queue.sv
// Bench for load_queue (default parameters: DEPTH 8, ROB_DEPTH 8, 32-bit).
module tb_load_queue;

  logic        clk_in;
  logic        rst_in;
  logic        alloc_valid_in;
  logic [2:0]  alloc_rob_ix_in;
  logic        alloc_ready_out;
  logic        addr_valid_in;
  logic [2:0]  addr_rob_ix_in;
  logic [31:0] addr_in;
  logic [7:0]  can_load_in;
  logic        flush_in;
  logic        mem_req_valid_out;
  logic        mem_req_ready_in;
  logic [31:0] mem_req_addr_out;
  logic [2:0]  mem_req_tag_out;
  logic        mem_resp_valid_in;
  logic [2:0]  mem_resp_tag_in;
  logic [31:0] mem_resp_data_in;
  logic        cdb_valid_out;
  logic [2:0]  cdb_rob_ix_out;
  logic [31:0] cdb_data_out;
  logic [3:0]  count_out;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [2:0]  rob;
    logic [31:0] data;
  } cdb_exp_t;

  cdb_exp_t sb_q[$];

  load_queue dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .alloc_valid_in    (alloc_valid_in),
    .alloc_rob_ix_in   (alloc_rob_ix_in),
    .alloc_ready_out   (alloc_ready_out),
    .addr_valid_in     (addr_valid_in),
    .addr_rob_ix_in    (addr_rob_ix_in),
    .addr_in           (addr_in),
    .can_load_in       (can_load_in),
    .flush_in          (flush_in),
    .mem_req_valid_out (mem_req_valid_out),
    .mem_req_ready_in  (mem_req_ready_in),
    .mem_req_addr_out  (mem_req_addr_out),
    .mem_req_tag_out   (mem_req_tag_out),
    .mem_resp_valid_in (mem_resp_valid_in),
    .mem_resp_tag_in   (mem_resp_tag_in),
    .mem_resp_data_in  (mem_resp_data_in),
    .cdb_valid_out     (cdb_valid_out),
    .cdb_rob_ix_out    (cdb_rob_ix_out),
    .cdb_data_out      (cdb_data_out),
    .count_out         (count_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    alloc_valid_in    = 1'b0;
    alloc_rob_ix_in   = '0;
    addr_valid_in     = 1'b0;
    addr_rob_ix_in    = '0;
    addr_in           = '0;
    can_load_in       = '0;
    flush_in          = 1'b0;
    mem_req_ready_in  = 1'b0;
    mem_resp_valid_in = 1'b0;
    mem_resp_tag_in   = '0;
    mem_resp_data_in  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    idle_inputs();
    rst_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  // Drive one response; when a CDB result is expected it is queued first
  // and popped when the broadcast appears one cycle later.
  task automatic send_resp(input logic [2:0] tag, input logic [31:0] data,
                           input logic [2:0] rob, input logic expect_cdb);
    cdb_exp_t e, got;
    @(negedge clk_in);
    mem_resp_valid_in = 1'b1;
    mem_resp_tag_in   = tag;
    mem_resp_data_in  = data;
    if (expect_cdb) begin
      e.rob  = rob;
      e.data = data;
      sb_q.push_back(e);
    end
    @(negedge clk_in);
    mem_resp_valid_in = 1'b0;
    #1;
    n_tests++;
    if (cdb_valid_out !== expect_cdb) begin
      n_fail++;
      $display("FAIL cdb_valid tag%0d: got %b expected %b", tag, cdb_valid_out, expect_cdb);
    end
    if (cdb_valid_out === 1'b1 && sb_q.size() > 0) begin
      got = sb_q.pop_front();
      n_tests++;
      if (cdb_rob_ix_out !== got.rob) begin
        n_fail++;
        $display("FAIL cdb_rob_ix: got %0d expected %0d", cdb_rob_ix_out, got.rob);
      end
      n_tests++;
      if (cdb_data_out !== got.data) begin
        n_fail++;
        $display("FAIL cdb_data: got %h expected %h", cdb_data_out, got.data);
      end
    end
    @(negedge clk_in);
    #1;
    n_tests++;
    if (cdb_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL cdb_pulse tag%0d: got %b expected 0", tag, cdb_valid_out);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_in = 1'b0;
    #1;
    n_tests++;
    if (count_out !== 4'd0 || mem_req_valid_out !== 1'b0 || cdb_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got count=%0d req=%b cdb=%b expected 0/0/0",
               count_out, mem_req_valid_out, cdb_valid_out);
    end
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    n_tests++;
    if (alloc_ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 1", alloc_ready_out);
    end
    n_tests++;
    if (mem_req_addr_out !== 32'h0 || mem_req_tag_out !== 3'd0 || cdb_data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h tag=%0d data=%h expected 0",
               mem_req_addr_out, mem_req_tag_out, cdb_data_out);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      alloc_valid_in  = 1'b1;
      alloc_rob_ix_in = 3'(i);
    end
    @(negedge clk_in);
    alloc_rob_ix_in = 3'd5;  // 9th request, must be ignored
    #1;
    n_tests++;
    if (count_out !== 4'd8) begin
      n_fail++;
      $display("FAIL fill_count: got %0d expected 8", count_out);
    end
    n_tests++;
    if (alloc_ready_out !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_ready: got %b expected 0", alloc_ready_out);
    end
    @(negedge clk_in);
    alloc_valid_in = 1'b0;
    #1;
    n_tests++;
    if (count_out !== 4'd8) begin
      n_fail++;
      $display("FAIL fill_ninth: got %0d expected 8", count_out);
    end
  endtask

  task automatic test_ooo_issue();
    @(negedge clk_in);
    addr_valid_in  = 1'b1;
    addr_rob_ix_in = 3'd3;
    addr_in        = 32'h100;
    @(negedge clk_in);
    addr_rob_ix_in = 3'd1;
    addr_in        = 32'h040;
    @(negedge clk_in);
    addr_valid_in = 1'b0;
    can_load_in   = 8'b0000_1000;
    #1;
    n_tests++;
    if (mem_req_valid_out !== 1'b1 || mem_req_addr_out !== 32'h100 || mem_req_tag_out !== 3'd3) begin
      n_fail++;
      $display("FAIL ooo_first: got v=%b addr=%h tag=%0d expected 1/100/3",
               mem_req_valid_out, mem_req_addr_out, mem_req_tag_out);
    end
    mem_req_ready_in = 1'b1;
    @(negedge clk_in);
    can_load_in      = 8'b0000_1010;
    mem_req_ready_in = 1'b0;
    #1;
    n_tests++;
    if (mem_req_valid_out !== 1'b1 || mem_req_addr_out !== 32'h040 || mem_req_tag_out !== 3'd1) begin
      n_fail++;
      $display("FAIL ooo_second: got v=%b addr=%h tag=%0d expected 1/040/1",
               mem_req_valid_out, mem_req_addr_out, mem_req_tag_out);
    end
    mem_req_ready_in = 1'b1;
    @(negedge clk_in);
    mem_req_ready_in = 1'b0;
    #1;
    n_tests++;
    if (mem_req_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL ooo_none_left: got %b expected 0", mem_req_valid_out);
    end
  endtask

  task automatic test_response_cdb();
    send_resp(3'd3, 32'hDEAD_BEEF, 3'd3, 1'b1);
    send_resp(3'd1, 32'h1234_5678, 3'd1, 1'b1);
    #1;
    n_tests++;
    if (count_out !== 4'd8) begin
      n_fail++;
      $display("FAIL head_blocks_retire: got %0d expected 8", count_out);
    end
    // Older entries 0 and 2 get addresses, issue and complete.
    @(negedge clk_in);
    addr_valid_in  = 1'b1;
    addr_rob_ix_in = 3'd0;
    addr_in        = 32'h000;
    @(negedge clk_in);
    addr_rob_ix_in = 3'd2;
    addr_in        = 32'h080;
    @(negedge clk_in);
    addr_valid_in    = 1'b0;
    can_load_in      = 8'b0000_0101;
    mem_req_ready_in = 1'b1;
    #1;
    n_tests++;
    if (mem_req_tag_out !== 3'd0) begin
      n_fail++;
      $display("FAIL oldest_first: got tag %0d expected 0", mem_req_tag_out);
    end
    @(negedge clk_in);
    @(negedge clk_in);
    mem_req_ready_in = 1'b0;
    #1;
    n_tests++;
    if (count_out !== 4'd8) begin
      n_fail++;
      $display("FAIL pre_retire_count: got %0d expected 8", count_out);
    end
    send_resp(3'd0, 32'h1111_1111, 3'd0, 1'b1);
    send_resp(3'd2, 32'h2222_2222, 3'd2, 1'b1);
    @(negedge clk_in);
    @(negedge clk_in);
    #1;
    n_tests++;
    if (count_out !== 4'd4 || alloc_ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL retire_count: got count=%0d ready=%b expected 4/1",
               count_out, alloc_ready_out);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk_in);
    alloc_valid_in  = 1'b1;
    alloc_rob_ix_in = 3'd5;
    @(negedge clk_in);
    alloc_valid_in = 1'b0;
    addr_valid_in  = 1'b1;
    addr_rob_ix_in = 3'd5;
    addr_in        = 32'h200;
    @(negedge clk_in);
    addr_valid_in = 1'b0;
    can_load_in   = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      if (c == 3) can_load_in = 8'h00;  // request is committed, must not drop
      #1;
      n_tests++;
      if (mem_req_valid_out !== 1'b1 || mem_req_addr_out !== 32'h200 || mem_req_tag_out !== 3'd0) begin
        n_fail++;
        $display("FAIL backpressure_c%0d: got v=%b addr=%h tag=%0d expected 1/200/0",
                 c, mem_req_valid_out, mem_req_addr_out, mem_req_tag_out);
      end
      @(negedge clk_in);
    end
    mem_req_ready_in = 1'b1;
    @(negedge clk_in);
    mem_req_ready_in = 1'b0;
    #1;
    n_tests++;
    if (mem_req_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_issued: got %b expected 0", mem_req_valid_out);
    end
    send_resp(3'd0, 32'hCAFE_F00D, 3'd5, 1'b1);
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      alloc_valid_in  = 1'b1;
      alloc_rob_ix_in = 3'(i);
    end
    @(negedge clk_in);
    alloc_valid_in   = 1'b0;
    can_load_in      = 8'b0000_0011;
    mem_req_ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr_valid_in  = 1'b1;
      addr_rob_ix_in = 3'(i);
      addr_in        = 32'h400 + 32'(i * 4);
      @(negedge clk_in);
    end
    addr_valid_in    = 1'b0;
    mem_req_ready_in = 1'b0;
    can_load_in      = 8'b0000_0111;  // entry 2 now eligible, but flush wins
    flush_in         = 1'b1;
    #1;
    n_tests++;
    if (mem_req_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_req: got %b expected 0", mem_req_valid_out);
    end
    @(negedge clk_in);
    flush_in       = 1'b0;
    alloc_valid_in = 1'b1;
    alloc_rob_ix_in = 3'd6;
    #1;
    n_tests++;
    if (alloc_ready_out !== 1'b0 || mem_req_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_ready: got ready=%b req=%b expected 0/0",
               alloc_ready_out, mem_req_valid_out);
    end
    @(negedge clk_in);
    alloc_valid_in = 1'b0;
    send_resp(3'd0, 32'hAAAA_0000, 3'd0, 1'b0);
    #1;
    n_tests++;
    if (alloc_ready_out !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_one_left: got %b expected 0", alloc_ready_out);
    end
    send_resp(3'd1, 32'hBBBB_0000, 3'd1, 1'b0);
    #1;
    n_tests++;
    if (count_out !== 4'd0 || alloc_ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_done: got count=%0d ready=%b expected 0/1",
               count_out, alloc_ready_out);
    end
    @(negedge clk_in);
    alloc_valid_in  = 1'b1;
    alloc_rob_ix_in = 3'd4;
    @(negedge clk_in);
    alloc_valid_in = 1'b0;
    #1;
    n_tests++;
    if (count_out !== 4'd1) begin
      n_fail++;
      $display("FAIL post_flush_alloc: got %0d expected 1", count_out);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk_in);
    alloc_valid_in  = 1'b1;
    alloc_rob_ix_in = 3'd6;
    @(negedge clk_in);
    alloc_rob_ix_in  = 3'd7;
    addr_valid_in    = 1'b1;
    addr_rob_ix_in   = 3'd6;
    addr_in          = 32'h300;
    can_load_in      = 8'hFF;
    mem_req_ready_in = 1'b1;
    @(negedge clk_in);
    alloc_valid_in = 1'b0;
    addr_rob_ix_in = 3'd7;
    addr_in        = 32'h304;
    @(negedge clk_in);
    addr_valid_in    = 1'b0;
    mem_req_ready_in = 1'b0;
    #1;
    n_tests++;
    if (mem_req_valid_out !== 1'b1 || mem_req_addr_out !== 32'h304 || mem_req_tag_out !== 3'd1) begin
      n_fail++;
      $display("FAIL pre_reset_req: got v=%b addr=%h tag=%0d expected 1/304/1",
               mem_req_valid_out, mem_req_addr_out, mem_req_tag_out);
    end
    rst_in = 1'b0;
    #1;
    n_tests++;
    if (mem_req_valid_out !== 1'b0 || mem_req_addr_out !== 32'h0 ||
        mem_req_tag_out !== 3'd0 || count_out !== 4'd0 || cdb_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b addr=%h tag=%0d count=%0d cdb=%b expected all 0",
               mem_req_valid_out, mem_req_addr_out, mem_req_tag_out, count_out, cdb_valid_out);
    end
    @(negedge clk_in);
    rst_in = 1'b1;
    send_resp(3'd0, 32'h0BAD_0BAD, 3'd6, 1'b0);
    #1;
    n_tests++;
    if (count_out !== 4'd0) begin
      n_fail++;
      $display("FAIL late_resp_count: got %0d expected 0", count_out);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_ooo_issue();
    test_response_cdb();
    test_backpressure();
    test_flush();
    test_async_reset();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d pending expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
